alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
Command-driven controller that sequences the team's 16-bit ALU datapath. It accepts register-to-register operation commands over a valid/ready handshake and reads operands from an internal register file. It drives the ALU's a/b/sel inputs, captures result and carry, writes back, and returns a response. MUL is built from 16 sequenced ALU ADD passes. The block sits between the instruction/command source and the combinational ALU.

Parameters:
NREG, 8, number of 16-bit registers in the internal file (power of 2, >=2); AW = log2(NREG) is a derived localparam.

Ports:
clk  input  1  sole clock, rising edge
rst_n  input  1  synchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command
cmd_op  input  4  opcode (ALU sel encoding plus MUL/LDI)
cmd_rd  input  AW  destination register
cmd_rs1  input  AW  source register A
cmd_rs2  input  AW  source register B
cmd_imm  input  16  immediate for LDI
alu_a  output  16  ALU operand a (registered)
alu_b  output  16  ALU operand b (registered)
alu_sel  output  4  ALU select (registered)
alu_result  input  16  ALU result (combinational return)
alu_carry  input  1  ALU carry out
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_data  output  16  value written to rd (0 on error)
rsp_carry  output  1  carry of operation
rsp_err  output  1  illegal opcode

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous, active-low. While rst_n=0 at a clk edge: state=IDLE; all registers=0; alu_a/alu_b/alu_sel=0; cmd_ready=0 during reset, 1 from the first edge after release; rsp_valid/rsp_data/rsp_carry/rsp_err=0.
- Legal ops: 0000 AND, 0110 OR, 0001 NOR, 0010 XOR, 0100 NOT, 0101 NAND, 1000 ADD, 1001 SUB, 1100 MUL, 1111 LDI. All other opcodes are illegal.
- FSM states: IDLE, ISSUE, MUL, RESP.
- IDLE: cmd_ready=1. On cmd_valid=1, latch rd, op, rs1 data, rs2 data.
  - Single-pass ALU op -> ISSUE, with alu_a=R[rs1], alu_b=R[rs2], alu_sel=op.
  - MUL -> MUL, with acc=0, mcand=R[rs1], mplier=R[rs2], iteration count=0.
  - LDI -> RESP; writes R[rd]=cmd_imm on the acceptance edge; rsp_data=imm, carry=0.
  - Illegal -> RESP with rsp_err=1, rsp_data=0, rsp_carry=0, no write.
- ISSUE: 1 cycle. At its end, R[rd]=alu_result, rsp_data=alu_result, rsp_carry=alu_carry -> RESP. Operation-to-rsp_valid latency is 2 edges after the acceptance edge.
- MUL: 16 cycles. Each cycle alu_sel=1000, alu_a=acc, alu_b = mplier[i] ? (mcand<<i) truncated to 16 bits : 0. Capture acc=alu_result at each edge. rsp_carry is the OR of all alu_carry values sampled. After i=15: R[rd]=acc (low 16 bits of product) -> RESP.
- RESP: rsp_valid=1 and response fields held stable until rsp_ready=1. Then rsp_valid=0 and state -> IDLE.
- cmd_ready=0 in every state except IDLE, so commands never overlap and there are no read-after-write hazards.
- rd may equal rs1/rs2; operands are latched before writeback.
- ALU outputs: alu_a/alu_b/alu_sel are held at last values outside ISSUE/MUL; the ALU result is ignored there.
- Reset mid-operation: reset asserted in any state aborts immediately. No writeback, no response, and all registers are cleared.

Optional Feature:
ALU_SEQ_ZERO_EN
- Defined: adds output port rsp_zero (1 bit), registered with rsp_data, high when rsp_data==0 and rsp_err==0; reset value 0.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset release, then LDI R1=0x00FF and LDI R2=0x0F0F -> each rsp_valid 1 edge after accept, rsp_data equals imm, carry=0.
- After the loads above, AND rd=3 rs1=1 rs2=2 -> alu_sel=0000 during ISSUE, rsp_data=0x000F 2 edges after accept, R3=0x000F.
- R1=0xFFFF, R2=0x0001, ADD -> rsp_data=0x0000, rsp_carry=1. Then SUB R2-R2 (0x0001-0x0001) -> rsp_data=0x0000.
- R1=0x0123, R2=0x0045, MUL -> 16 ADD cycles, then rsp_data=0x4E6F, rsp_carry=0. A 0x0100*0x0100 MUL -> rsp_data=0x0000.
- Illegal opcode 0011 -> rsp_err=1, rsp_data=0, no register change. Hold rsp_ready=0 for 5 cycles -> rsp_valid stays high, cmd_ready stays 0.
- Assert rst_n=0 at MUL cycle 7 -> next edge: state IDLE, rsp_valid=0, all registers 0, no writeback.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Command-driven sequencer for the 16-bit combinational ALU, with an internal register file.
// Defining ALU_SEQ_ZERO_EN adds the rsp_zero output flag.
module alu_op_sequencer #(
    parameter int NREG = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [3:0]              cmd_op,
    input  logic [$clog2(NREG)-1:0] cmd_rd,
    input  logic [$clog2(NREG)-1:0] cmd_rs1,
    input  logic [$clog2(NREG)-1:0] cmd_rs2,
    input  logic [15:0]             cmd_imm,
    output logic [15:0]             alu_a,
    output logic [15:0]             alu_b,
    output logic [3:0]              alu_sel,
    input  logic [15:0]             alu_result,
    input  logic                    alu_carry,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [15:0]             rsp_data,
    output logic                    rsp_carry,
`ifdef ALU_SEQ_ZERO_EN
    output logic                    rsp_zero,
`endif
    output logic                    rsp_err
);
    localparam int AW = $clog2(NREG);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_NOR  = 4'b0001;
    localparam logic [3:0] OP_XOR  = 4'b0010;
    localparam logic [3:0] OP_NOT  = 4'b0100;
    localparam logic [3:0] OP_NAND = 4'b0101;
    localparam logic [3:0] OP_ADD  = 4'b1000;
    localparam logic [3:0] OP_SUB  = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1100;
    localparam logic [3:0] OP_LDI  = 4'b1111;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_MUL, S_RESP} state_e;

    state_e         state_q, state_d;
    logic [15:0]    regs_q [NREG];
    logic [15:0]    regs_d [NREG];
    logic [AW-1:0]  rd_q, rd_d;
    logic [15:0]    mcand_q, mcand_d;
    logic [15:0]    mplier_q, mplier_d;
    logic [3:0]     iter_q, iter_d;
    logic [15:0]    alu_a_q, alu_a_d;
    logic [15:0]    alu_b_q, alu_b_d;
    logic [3:0]     alu_sel_q, alu_sel_d;
    logic           cmd_ready_q, cmd_ready_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [15:0]    rsp_data_q, rsp_data_d;
    logic           rsp_carry_q, rsp_carry_d;
    logic           rsp_err_q, rsp_err_d;

    // Partial product for multiplier bit idx; bits shifted past 15 are dropped.
    function automatic logic [15:0] mul_term(input logic [15:0] mcand,
                                             input logic [15:0] mplier,
                                             input logic [3:0]  idx);
        if (mplier[idx]) begin
            mul_term = mcand << idx;
        end else begin
            mul_term = 16'd0;
        end
    endfunction

    // Next-state, datapath and response computation.
    always_comb begin
        state_d     = state_q;
        regs_d      = regs_q;
        rd_d        = rd_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        iter_d      = iter_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_carry_d = rsp_carry_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    rd_d        = cmd_rd;
                    case (cmd_op)
                        OP_AND, OP_OR, OP_NOR, OP_XOR, OP_NOT, OP_NAND, OP_ADD, OP_SUB: begin
                            alu_a_d   = regs_q[cmd_rs1];
                            alu_b_d   = regs_q[cmd_rs2];
                            alu_sel_d = cmd_op;
                            state_d   = S_ISSUE;
                        end
                        OP_MUL: begin
                            // alu_a doubles as the running accumulator across passes
                            mcand_d     = regs_q[cmd_rs1];
                            mplier_d    = regs_q[cmd_rs2];
                            iter_d      = 4'd0;
                            alu_a_d     = 16'd0;
                            alu_b_d     = mul_term(regs_q[cmd_rs1], regs_q[cmd_rs2], 4'd0);
                            alu_sel_d   = OP_ADD;
                            rsp_carry_d = 1'b0;
                            state_d     = S_MUL;
                        end
                        OP_LDI: begin
                            regs_d[cmd_rd] = cmd_imm;
                            rsp_data_d     = cmd_imm;
                            rsp_carry_d    = 1'b0;
                            rsp_err_d      = 1'b0;
                            rsp_valid_d    = 1'b1;
                            state_d        = S_RESP;
                        end
                        default: begin
                            rsp_data_d  = 16'd0;
                            rsp_carry_d = 1'b0;
                            rsp_err_d   = 1'b1;
                            rsp_valid_d = 1'b1;
                            state_d     = S_RESP;
                        end
                    endcase
                end else begin
                    cmd_ready_d = 1'b1;
                end
            end
            S_ISSUE: begin
                regs_d[rd_q] = alu_result;
                rsp_data_d   = alu_result;
                rsp_carry_d  = alu_carry;
                rsp_err_d    = 1'b0;
                rsp_valid_d  = 1'b1;
                state_d      = S_RESP;
            end
            S_MUL: begin
                rsp_carry_d = rsp_carry_q | alu_carry;
                if (iter_q == 4'd15) begin
                    regs_d[rd_q] = alu_result;
                    rsp_data_d   = alu_result;
                    rsp_err_d    = 1'b0;
                    rsp_valid_d  = 1'b1;
                    state_d      = S_RESP;
                end else begin
                    iter_d  = iter_q + 4'd1;
                    alu_a_d = alu_result;
                    alu_b_d = mul_term(mcand_q, mplier_q, iter_q + 4'd1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef ALU_SEQ_ZERO_EN
    logic rsp_zero_q, rsp_zero_d;

    // Zero flag is captured only when a new response is produced.
    always_comb begin
        if (rsp_valid_d && !rsp_valid_q) begin
            rsp_zero_d = (rsp_data_d == 16'd0) && !rsp_err_d;
        end else begin
            rsp_zero_d = rsp_zero_q;
        end
    end

    // Zero flag register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_zero_q <= 1'b0;
        end else begin
            rsp_zero_q <= rsp_zero_d;
        end
    end

    assign rsp_zero = rsp_zero_q;
`endif

    // State, register file and registered outputs; reset aborts any operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= 16'd0;
            end
            rd_q        <= '0;
            mcand_q     <= 16'd0;
            mplier_q    <= 16'd0;
            iter_q      <= 4'd0;
            alu_a_q     <= 16'd0;
            alu_b_q     <= 16'd0;
            alu_sel_q   <= 4'd0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 16'd0;
            rsp_carry_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            regs_q      <= regs_d;
            rd_q        <= rd_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            iter_q      <= iter_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_carry = rsp_carry_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU, arithmetic reference model, directed plus random commands.
module tb_alu_op_sequencer;
    localparam int NREG = 8;
    localparam int AW   = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [3:0]    cmd_op;
    logic [AW-1:0] cmd_rd, cmd_rs1, cmd_rs2;
    logic [15:0]   cmd_imm;
    logic [15:0]   alu_a, alu_b;
    logic [3:0]    alu_sel;
    logic [15:0]   alu_result;
    logic          alu_carry;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [15:0]   rsp_data;
    logic          rsp_carry;
    logic          rsp_err;
`ifdef ALU_SEQ_ZERO_EN
    logic          rsp_zero;
`endif

    int passes = 0;
    int fails  = 0;
    int total  = 0;

    logic [15:0] mregs [NREG];
    logic [31:0] rnd;
    logic [3:0]  legal_ops [10] = '{4'b0000, 4'b0110, 4'b0001, 4'b0010, 4'b0100,
                                   4'b0101, 4'b1000, 4'b1001, 4'b1100, 4'b1111};

    alu_op_sequencer #(.NREG(NREG)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_carry(rsp_carry),
`ifdef ALU_SEQ_ZERO_EN
        .rsp_zero(rsp_zero),
`endif
        .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    // Behavioural combinational ALU; carry is carry-out for ADD and borrow for SUB.
    always_comb begin
        alu_result = 16'd0;
        alu_carry  = 1'b0;
        case (alu_sel)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0110: alu_result = alu_a | alu_b;
            4'b0001: alu_result = ~(alu_a | alu_b);
            4'b0010: alu_result = alu_a ^ alu_b;
            4'b0100: alu_result = ~alu_a;
            4'b0101: alu_result = ~(alu_a & alu_b);
            4'b1000: {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
            4'b1001: {alu_carry, alu_result} = {1'b0, alu_a} - {1'b0, alu_b};
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: computes expected response from the operation's definition and updates mregs.
    task automatic model_op(input logic [3:0] op, input int rd, input int rs1, input int rs2,
                            input logic [15:0] imm, output logic [15:0] d, output logic c,
                            output logic e, output int lat);
        int a, b, acc, t;
        a = int'(mregs[rs1]);
        b = int'(mregs[rs2]);
        c = 1'b0; e = 1'b0; lat = 2; d = 16'd0;
        case (op)
            4'b0000: d = 16'(a & b);
            4'b0110: d = 16'(a | b);
            4'b0001: d = 16'(~(a | b));
            4'b0010: d = 16'(a ^ b);
            4'b0100: d = 16'(~a);
            4'b0101: d = 16'(~(a & b));
            4'b1000: begin d = 16'(a + b); c = (a + b) > 65535; end
            4'b1001: begin d = 16'(a - b); c = a < b; end
            4'b1100: begin
                acc = 0;
                for (int i = 0; i < 16; i++) begin
                    t = ((b >> i) & 1) != 0 ? ((a << i) & 32'hFFFF) : 0;
                    acc = acc + t;
                    if (acc > 65535) c = 1'b1;
                    acc = acc & 32'hFFFF;
                end
                d = 16'(a * b);
                lat = 17;
            end
            4'b1111: begin d = imm; lat = 1; end
            default: begin e = 1'b1; lat = 1; end
        endcase
        if (!e) mregs[rd] = d;
    endtask

    // Issues one command at #1 after an edge and checks timing, ALU drive and response.
    task automatic do_cmd(input logic [3:0] op, input int rd, input int rs1, input int rs2,
                          input logic [15:0] imm, input int hold);
        logic [15:0] ed, a, b;
        logic ec, ee;
        int elat, lat;
        a = mregs[rs1];
        b = mregs[rs2];
        model_op(op, rd, rs1, rs2, imm, ed, ec, ee, elat);
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_op = op; cmd_rd = AW'(rd); cmd_rs1 = AW'(rs1); cmd_rs2 = AW'(rs2); cmd_imm = imm;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        rnd = $urandom; cmd_op = rnd[3:0]; cmd_rd = rnd[6:4]; cmd_rs1 = rnd[9:7];
        cmd_rs2 = rnd[12:10]; cmd_imm = rnd[31:16];
        check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
        if (elat == 2) begin
            check("issue_sel", 32'(alu_sel), 32'(op));
            check("issue_a", 32'(alu_a), 32'(a));
            check("issue_b", 32'(alu_b), 32'(b));
        end else if (elat == 17) begin
            check("mul_sel", 32'(alu_sel), 32'h8);
            check("mul_a0", 32'(alu_a), 32'd0);
        end
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(elat));
        check("rsp_data", 32'(rsp_data), 32'(ed));
        check("rsp_carry", 32'(rsp_carry), 32'(ec));
        check("rsp_err", 32'(rsp_err), 32'(ee));
`ifdef ALU_SEQ_ZERO_EN
        check("rsp_zero", 32'(rsp_zero), 32'((ed == 16'd0) && !ee));
`endif
        if (hold > 0) begin
            repeat (hold) begin @(posedge clk); #1; end
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_ready", 32'(cmd_ready), 32'd0);
            check("hold_data", 32'(rsp_data), 32'(ed));
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("rsp_drop", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int hold;
        rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_op = 4'd0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_imm = 16'd0;
        for (int i = 0; i < NREG; i++) mregs[i] = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_alu", {alu_a, alu_b[11:0], alu_sel}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_cmd_ready", 32'(cmd_ready), 32'd1);

        do_cmd(4'b1111, 1, 0, 0, 16'h00FF, 0);
        do_cmd(4'b1111, 2, 0, 0, 16'h0F0F, 0);
        do_cmd(4'b0000, 3, 1, 2, 16'd0, 0);
        do_cmd(4'b0110, 4, 3, 3, 16'd0, 0);
        do_cmd(4'b1111, 1, 0, 0, 16'hFFFF, 0);
        do_cmd(4'b1111, 2, 0, 0, 16'h0001, 0);
        do_cmd(4'b1000, 5, 1, 2, 16'd0, 1);
        do_cmd(4'b1001, 6, 2, 2, 16'd0, 0);
        do_cmd(4'b1111, 1, 0, 0, 16'h0123, 0);
        do_cmd(4'b1111, 2, 0, 0, 16'h0045, 0);
        do_cmd(4'b1100, 7, 1, 2, 16'd0, 0);
        do_cmd(4'b1111, 1, 0, 0, 16'h0100, 0);
        do_cmd(4'b1111, 2, 0, 0, 16'h0100, 0);
        do_cmd(4'b1100, 0, 1, 2, 16'd0, 0);
        do_cmd(4'b0011, 7, 1, 2, 16'd0, 5);
        do_cmd(4'b0110, 6, 7, 7, 16'd0, 0);
        do_cmd(4'b1100, 2, 2, 2, 16'd0, 0);

        for (int n = 0; n < 60; n++) begin
            rnd = $urandom;
            hold = int'(rnd[17:16]) % 3;
            if (rnd[31:28] == 4'd0) begin
                do_cmd(4'b1010, int'(rnd[2:0]), int'(rnd[5:3]), int'(rnd[8:6]), rnd[31:16], hold);
            end else begin
                do_cmd(legal_ops[$urandom_range(0, 9)], int'(rnd[2:0]), int'(rnd[5:3]),
                       int'(rnd[8:6]), rnd[31:16], hold);
            end
        end

        do_cmd(4'b1111, 1, 0, 0, 16'h1357, 0);
        do_cmd(4'b1111, 2, 0, 0, 16'hFFFF, 0);
        check("mid_ready", 32'(cmd_ready), 32'd1);
        cmd_op = 4'b1100; cmd_rd = 3'd3; cmd_rs1 = 3'd1; cmd_rs2 = 3'd2; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_cmd_ready", 32'(cmd_ready), 32'd0);
        check("abort_alu", {alu_a, alu_b[11:0], alu_sel}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < NREG; i++) mregs[i] = 16'd0;
        @(posedge clk); #1;
        for (int i = 0; i < NREG; i++) do_cmd(4'b0110, i, i, i, 16'd0, 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
